// File: rtl/argmax_pkg.sv
`default_nettype none
// ============================================================================
// Module      : argmax_pkg
// Description : Shared types and defaults for the sequential argmax/argmin selector.
// Revision    : 1.0 - initial release
// ============================================================================
package argmax_pkg;

    localparam int unsigned ARGMAX_N_DEFAULT = 4;
    localparam int unsigned ARGMAX_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } argmax_state_t;

    typedef enum logic {
        SEL_MAX = 1'b0,
        SEL_MIN = 1'b1
    } argmax_mode_t;

endpackage
`default_nettype wire

// File: rtl/argmax_cmp.sv
`default_nettype none
// ============================================================================
// Module      : argmax_cmp
// Description : Decides whether the current candidate replaces the best entry.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_cmp
    import argmax_pkg::*;
#(
    parameter int unsigned W = ARGMAX_W_DEFAULT
) (
    input  logic [W-1:0]  cur,
    input  logic [W-1:0]  best,
    input  logic          found,
    input  logic          eligible,
    input  argmax_mode_t  mode,
    output logic          take
);

    logic better;

    // Strict compare keeps the earlier (lower) index on ties.
    always_comb begin
        better = (mode == SEL_MIN) ? (cur < best) : (cur > best);
        take   = eligible && (!found || better);
    end

endmodule
`default_nettype wire

// File: rtl/argmax_seq.sv
`default_nettype none
// ============================================================================
// Module      : argmax_seq
// Description : Captures N scores and a mask, scans one channel per clock and
//               reports the index and value of the max/min eligible channel.
// Revision    : 1.0 - initial release
// ============================================================================
module argmax_seq
    import argmax_pkg::*;
#(
    parameter int unsigned N     = ARGMAX_N_DEFAULT,
    parameter int unsigned W     = ARGMAX_W_DEFAULT,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               start,
    input  logic [N*W-1:0]     vals,
    input  logic [N-1:0]       mask,
    input  logic               mode,
    output logic               busy,
    output logic               done,
    output logic [IDX_W-1:0]   ret,
    output logic [W-1:0]       ret_val,
    output logic               none_valid
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    argmax_state_t     state_q, state_d;
    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [N*W-1:0]    vals_q, vals_d;
    logic [N-1:0]      mask_q, mask_d;
    argmax_mode_t      mode_q, mode_d;
    logic              found_q, found_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic [W-1:0]      best_val_q, best_val_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [IDX_W-1:0]  ret_q, ret_d;
    logic [W-1:0]      ret_val_q, ret_val_d;
    logic              none_valid_q, none_valid_d;

    logic [W-1:0]      vals_arr [N];
    logic [W-1:0]      cur_val;
    logic              cur_elig;
    logic              take;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign vals_arr[g] = vals_q[g*W +: W];
    end

    assign cur_val  = vals_arr[cnt_q];
    assign cur_elig = mask_q[cnt_q];

    argmax_cmp #(
        .W (W)
    ) u_cmp (
        .cur      (cur_val),
        .best     (best_val_q),
        .found    (found_q),
        .eligible (cur_elig),
        .mode     (mode_q),
        .take     (take)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        vals_d       = vals_q;
        mask_d       = mask_q;
        mode_d       = mode_q;
        found_d      = found_q;
        best_idx_d   = best_idx_q;
        best_val_d   = best_val_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        ret_d        = ret_q;
        ret_val_d    = ret_val_q;
        none_valid_d = none_valid_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    vals_d     = vals;
                    mask_d     = mask;
                    mode_d     = argmax_mode_t'(mode);
                    found_d    = 1'b0;
                    best_idx_d = '0;
                    best_val_d = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = S_SCAN;
                end
            end
            S_SCAN: begin
                if (take) begin
                    best_idx_d = cnt_q;
                    best_val_d = cur_val;
                    found_d    = 1'b1;
                end
                if (cnt_q == LAST_IDX) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                // Best registers start at zero, so an empty mask yields ret=0, ret_val=0.
                ret_d        = best_idx_q;
                ret_val_d    = best_val_q;
                none_valid_d = !found_q;
                done_d       = 1'b1;
                state_d      = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            vals_q       <= '0;
            mask_q       <= '0;
            mode_q       <= SEL_MAX;
            found_q      <= 1'b0;
            best_idx_q   <= '0;
            best_val_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            ret_q        <= '0;
            ret_val_q    <= '0;
            none_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            vals_q       <= vals_d;
            mask_q       <= mask_d;
            mode_q       <= mode_d;
            found_q      <= found_d;
            best_idx_q   <= best_idx_d;
            best_val_q   <= best_val_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            ret_q        <= ret_d;
            ret_val_q    <= ret_val_d;
            none_valid_q <= none_valid_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign ret        = ret_q;
    assign ret_val    = ret_val_q;
    assign none_valid = none_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_argmax_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_argmax_seq
// Description : Directed and randomized checks of argmax_seq (N=4/W=32 and N=5/W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_argmax_seq;

    logic Clk = 1'b0;
    logic Reset_n;
    always #5 Clk = ~Clk;

    logic         start4, mode4, busy4, done4, nv4;
    logic [127:0] vals4;
    logic [3:0]   mask4;
    logic [1:0]   ret4;
    logic [31:0]  ret_val4;

    logic         start5, mode5, busy5, done5, nv5;
    logic [39:0]  vals5;
    logic [4:0]   mask5;
    logic [2:0]   ret5;
    logic [7:0]   ret_val5;

    int n_checks = 0;
    int n_fail   = 0;

    argmax_seq #(.N(4), .W(32)) dut4 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start4), .vals(vals4), .mask(mask4),
        .mode(mode4), .busy(busy4), .done(done4), .ret(ret4), .ret_val(ret_val4),
        .none_valid(nv4)
    );

    argmax_seq #(.N(5), .W(8)) dut5 (
        .Clk(Clk), .Reset_n(Reset_n), .start(start5), .vals(vals5), .mask(mask5),
        .mode(mode5), .busy(busy5), .done(done5), .ret(ret5), .ret_val(ret_val5),
        .none_valid(nv5)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: find the extreme eligible value first, then its lowest index.
    function automatic void model(input logic [255:0] v, input int n, input int w,
                                  input logic [7:0] m, input logic md,
                                  output int idx, output logic [63:0] val, output bit none);
        logic [63:0] ext, vi, msk;
        msk  = (64'd1 << w) - 64'd1;
        none = 1'b1;
        ext  = '0;
        idx  = 0;
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                vi = 64'(v >> (i * w)) & msk;
                if (none) ext = vi;
                else      ext = md ? ((vi < ext) ? vi : ext) : ((vi > ext) ? vi : ext);
                none = 1'b0;
            end
        end
        for (int i = n - 1; i >= 0; i--) begin
            if (m[i] && ((64'(v >> (i * w)) & msk) == ext)) idx = i;
        end
        val = none ? 64'd0 : ext;
        if (none) idx = 0;
    endfunction

    // ctl: 0 = plain request, 1 = disturb inputs/start during SCAN, 2 = reset mid-SCAN
    task automatic req4(input logic [127:0] v, input logic [3:0] m, input logic md,
                        input int ctl, input string tag);
        int eidx, first_done, n_done, n_busy;
        logic [63:0] eval;
        bit enone;
        model(256'(v), 4, 32, 8'(m), md, eidx, eval, enone);
        first_done = 0;
        n_done     = 0;
        n_busy     = 0;
        @(negedge Clk);
        vals4 = v; mask4 = m; mode4 = md; start4 = 1'b1;
        @(negedge Clk);
        start4 = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            if (k > 1) @(negedge Clk);
            if (busy4) n_busy++;
            if (done4) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
            if (ctl == 1 && k == 2) begin
                vals4 = ~v; mask4 = 4'hF; mode4 = ~md; start4 = 1'b1;
            end
            if (ctl == 1 && k == 3) start4 = 1'b0;
            if (ctl == 2 && k == 2) begin
                Reset_n = 1'b0;
                #1;
                check_val({tag, "_async_busy"}, 64'(busy4), 64'd0);
                check_val({tag, "_async_ret"}, 64'(ret4), 64'd0);
                check_val({tag, "_async_val"}, 64'(ret_val4), 64'd0);
                #1;
                Reset_n = 1'b1;
            end
        end
        if (ctl == 2) begin
            check_val({tag, "_no_done"}, 64'(n_done), 64'd0);
            check_val({tag, "_ret"}, 64'(ret4), 64'd0);
            check_val({tag, "_val"}, 64'(ret_val4), 64'd0);
            check_val({tag, "_none"}, 64'(nv4), 64'd0);
        end else begin
            check_val({tag, "_ndone"}, 64'(n_done), 64'd1);
            check_val({tag, "_latency"}, 64'(first_done - 1), 64'd5);
            check_val({tag, "_busy_cycles"}, 64'(n_busy), 64'd4);
            check_val({tag, "_ret"}, 64'(ret4), 64'(eidx));
            check_val({tag, "_val"}, 64'(ret_val4), eval);
            check_val({tag, "_none"}, 64'(nv4), 64'(enone));
        end
    endtask

    task automatic req5(input logic [39:0] v, input logic [4:0] m, input logic md);
        int eidx, k;
        logic [63:0] eval;
        bit enone;
        model(256'(v), 5, 8, 8'(m), md, eidx, eval, enone);
        @(negedge Clk);
        vals5 = v; mask5 = m; mode5 = md; start5 = 1'b1;
        @(negedge Clk);
        start5 = 1'b0;
        k = 1;
        while (!done5 && k < 20) begin
            @(negedge Clk);
            k++;
        end
        check_val("n5_latency", 64'(k - 1), 64'd6);
        check_val("n5_ret", 64'(ret5), 64'(eidx));
        check_val("n5_val", 64'(ret_val5), eval);
        check_val("n5_none", 64'(nv5), 64'(enone));
    endtask

    function automatic logic [7:0] rand_byte();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        logic [39:0]  rv5;
        logic [127:0] rv4;
        Reset_n = 1'b0;
        start4 = 1'b0; vals4 = '0; mask4 = '0; mode4 = 1'b0;
        start5 = 1'b0; vals5 = '0; mask5 = '0; mode5 = 1'b0;
        repeat (3) @(negedge Clk);
        check_val("rst_busy", 64'(busy4), 64'd0);
        check_val("rst_done", 64'(done4), 64'd0);
        check_val("rst_ret", 64'(ret4), 64'd0);
        check_val("rst_val", 64'(ret_val4), 64'd0);
        check_val("rst_none", 64'(nv4), 64'd0);
        Reset_n = 1'b1;

        req4({32'd12, 32'd90, 32'd7, 32'd40}, 4'hF, 1'b0, 0, "basic_max");
        req4({32'd9, 32'd9, 32'd9, 32'd5}, 4'hF, 1'b0, 0, "tie_max");
        req4({32'd9, 32'd9, 32'd9, 32'd5}, 4'hF, 1'b1, 0, "tie_min");
        req4({32'd30, 32'd3, 32'd20, 32'd1}, 4'b1010, 1'b1, 0, "mask_min");
        req4({32'd30, 32'd3, 32'd20, 32'd1}, 4'b0000, 1'b1, 0, "mask_zero");
        req4({32'd12, 32'd90, 32'd7, 32'd40}, 4'hF, 1'b0, 1, "disturb");
        req4({32'd1, 32'd2, 32'd3, 32'd4}, 4'hF, 1'b0, 2, "reset_mid");
        req4({32'd1, 32'd2, 32'd3, 32'd4}, 4'hF, 1'b1, 0, "after_reset");
        for (int r = 0; r < 20; r++) begin
            rv4 = {$urandom, $urandom, $urandom, $urandom};
            req4(rv4, 4'($urandom), 1'($urandom), 0, "rand4");
        end

        req5({5{8'hFF}}, 5'h1F, 1'b1);
        req5({5{8'h00}}, 5'h1F, 1'b0);
        for (int r = 0; r < 1000; r++) begin
            rv5 = {rand_byte(), rand_byte(), rand_byte(), rand_byte(), rand_byte()};
            req5(rv5, 5'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
